// File: rtl/data_path_if.sv
// Sequencer-facing control strobes and observation bus of data_path.
// Adds the SUB strobe when DATAPATH_SUB_EN is defined.
interface data_path_if;
  logic        PCout, Zlowout, Zhighout, MDRout;
  logic        Csignout, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin;
  logic        Yin, Zlowin, Zhighin, Rin;
  logic        Gra, Grb, Grc;
  logic        IncPC, ADD, MD_read;
  logic        Read, Write;
`ifdef DATAPATH_SUB_EN
  logic        SUB;
`endif
  logic [31:0] Mdatain;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] bus_out, ir_out, pc_out;

  modport master (
`ifdef DATAPATH_SUB_EN
    output SUB,
`endif
    output PCout, Zlowout, Zhighout, MDRout,
    output Csignout, Rout, BAout,
    output PCin, IRin, MARin, MDRin,
    output Yin, Zlowin, Zhighin, Rin,
    output Gra, Grb, Grc,
    output IncPC, ADD, MD_read,
    output Read, Write, Mdatain,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write,
    input  bus_out, ir_out, pc_out
  );

  modport slave (
`ifdef DATAPATH_SUB_EN
    input  SUB,
`endif
    input  PCout, Zlowout, Zhighout, MDRout,
    input  Csignout, Rout, BAout,
    input  PCin, IRin, MARin, MDRin,
    input  Yin, Zlowin, Zhighin, Rin,
    input  Gra, Grb, Grc,
    input  IncPC, ADD, MD_read,
    input  Read, Write, Mdatain,
    output mem_addr, mem_wdata,
    output mem_read, mem_write,
    output bus_out, ir_out, pc_out
  );
endinterface

// File: rtl/data_path.sv
// Strobe-driven 32-bit bus datapath: regfile, PC/IR/MAR/MDR/Y/Z, ALU.
// Optional subtract via DATAPATH_SUB_EN.
module data_path #(
  parameter int          REG_COUNT = 16,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic        clock,
  input logic        clear,
  data_path_if.slave dp
);

  logic [31:0] rf [REG_COUNT];
  logic [31:0] pc, ir, mar, mdr, y, zlo, zhi;
  logic [31:0] bus, c_sext, sel, sum;
  logic [3:0]  ra, rb, rc, idx;
  logic [63:0] alu;

  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];
  assign c_sext = {{13{ir[18]}}, ir[18:0]};

  always_comb begin
    idx = 4'd0;
    if (dp.Gra)      idx = ra;
    else if (dp.Grb) idx = rb;
    else if (dp.Grc) idx = rc;
  end

  assign sel = rf[idx];

  always_comb begin
    bus = '0;
    if (dp.MDRout)        bus = mdr;
    else if (dp.Zlowout)  bus = zlo;
    else if (dp.Zhighout) bus = zhi;
    else if (dp.PCout)    bus = pc;
    else if (dp.Csignout) bus = c_sext;
    else if (dp.Rout)     bus = sel;
    else if (dp.BAout)    bus = (idx == 4'd0) ? '0 : sel;
  end

  always_comb begin
    sum = '0;
    alu = '0;
    if (dp.IncPC) begin
      sum = bus + 32'd1;
      alu = {32'h0, sum};
    end
`ifdef DATAPATH_SUB_EN
    else if (dp.SUB) begin
      sum = y - bus;
      alu = {{32{sum[31]}}, sum};
    end
`endif
    else if (dp.ADD) begin
      sum = y + bus;
      alu = {{32{sum[31]}}, sum};
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
      pc  <= RESET_PC;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      zlo <= '0;
      zhi <= '0;
    end else begin
      if (dp.Rin)     rf[idx] <= bus;
      if (dp.PCin)    pc  <= bus;
      if (dp.IRin)    ir  <= bus;
      if (dp.MARin)   mar <= bus;
      if (dp.MDRin)   mdr <= dp.MD_read ? dp.Mdatain : bus;
      if (dp.Yin)     y   <= bus;
      if (dp.Zlowin)  zlo <= alu[31:0];
      if (dp.Zhighin) zhi <= alu[63:32];
    end
  end

  assign dp.mem_addr  = mar;
  assign dp.mem_wdata = mdr;
  assign dp.mem_read  = dp.Read;
  assign dp.mem_write = dp.Write;
  assign dp.bus_out   = bus;
  assign dp.ir_out    = ir;
  assign dp.pc_out    = pc;

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed micro-op table, mid-run reset,
// then random strobes against a behavioural model.
module tb_data_path;

  localparam logic [23:0] PCO  = 24'h000001;
  localparam logic [23:0] ZLO  = 24'h000002;
  localparam logic [23:0] ZHO  = 24'h000004;
  localparam logic [23:0] MDRO = 24'h000008;
  localparam logic [23:0] CSO  = 24'h000010;
  localparam logic [23:0] RO   = 24'h000020;
  localparam logic [23:0] BAO  = 24'h000040;
  localparam logic [23:0] PCI  = 24'h000080;
  localparam logic [23:0] IRI  = 24'h000100;
  localparam logic [23:0] MARI = 24'h000200;
  localparam logic [23:0] MDRI = 24'h000400;
  localparam logic [23:0] YI   = 24'h000800;
  localparam logic [23:0] ZLI  = 24'h001000;
  localparam logic [23:0] ZHI  = 24'h002000;
  localparam logic [23:0] RI   = 24'h004000;
  localparam logic [23:0] GRA  = 24'h008000;
  localparam logic [23:0] GRB  = 24'h010000;
  localparam logic [23:0] GRC  = 24'h020000;
  localparam logic [23:0] INC  = 24'h040000;
  localparam logic [23:0] ADDS = 24'h080000;
  localparam logic [23:0] MDRD = 24'h100000;
  localparam logic [23:0] RDS  = 24'h200000;
  localparam logic [23:0] WRS  = 24'h400000;
  localparam logic [23:0] SUBS = 24'h800000;

  typedef struct packed {
    logic [23:0] c;
    logic [31:0] md;
    logic [31:0] eb;
    logic [2:0]  pk;
    logic [31:0] pv;
  } vec_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  data_path_if dif ();

  data_path dut (.clock(clock), .clear(clear), .dp(dif));

  always #5 clock = ~clock;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zl, m_zh;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    foreach (m_r[i]) m_r[i] = 32'h0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
    m_y = 0; m_zl = 0; m_zh = 0;
  endfunction

  function automatic int m_idx(logic [23:0] c);
    if (|(c & GRA)) return int'(m_ir[26:23]);
    if (|(c & GRB)) return int'(m_ir[22:19]);
    if (|(c & GRC)) return int'(m_ir[18:15]);
    return 0;
  endfunction

  function automatic logic [31:0] m_bus(logic [23:0] c);
    int k;
    k = m_idx(c);
    if (|(c & MDRO)) return m_mdr;
    if (|(c & ZLO))  return m_zl;
    if (|(c & ZHO))  return m_zh;
    if (|(c & PCO))  return m_pc;
    if (|(c & CSO))  return 32'(int'(m_ir << 13) >>> 13);
    if (|(c & RO))   return m_r[k];
    if (|(c & BAO))  return (k == 0) ? 32'h0 : m_r[k];
    return 32'h0;
  endfunction

  function automatic void m_clk(logic [23:0] c, logic [31:0] md);
    logic [31:0] b;
    logic [63:0] res;
    int k;
    b = m_bus(c);
    k = m_idx(c);
    res = 64'h0;
    if (|(c & INC)) res = 64'(b) + 64'd1;
`ifdef DATAPATH_SUB_EN
    else if (|(c & SUBS)) res = 64'(longint'(int'(m_y - b)));
`endif
    else if (|(c & ADDS)) res = 64'(longint'(int'(m_y + b)));
    res[63:32] = (|(c & INC)) ? 32'h0 : res[63:32];
    if (|(c & RI))   m_r[k] = b;
    if (|(c & PCI))  m_pc = b;
    if (|(c & IRI))  m_ir = b;
    if (|(c & MARI)) m_mar = b;
    if (|(c & MDRI)) m_mdr = (|(c & MDRD)) ? md : b;
    if (|(c & YI))   m_y = b;
    if (|(c & ZLI))  m_zl = res[31:0];
    if (|(c & ZHI))  m_zh = res[63:32];
  endfunction

  task automatic drive(logic [23:0] c, logic [31:0] md);
    dif.PCout    = |(c & PCO);
    dif.Zlowout  = |(c & ZLO);
    dif.Zhighout = |(c & ZHO);
    dif.MDRout   = |(c & MDRO);
    dif.Csignout = |(c & CSO);
    dif.Rout     = |(c & RO);
    dif.BAout    = |(c & BAO);
    dif.PCin     = |(c & PCI);
    dif.IRin     = |(c & IRI);
    dif.MARin    = |(c & MARI);
    dif.MDRin    = |(c & MDRI);
    dif.Yin      = |(c & YI);
    dif.Zlowin   = |(c & ZLI);
    dif.Zhighin  = |(c & ZHI);
    dif.Rin      = |(c & RI);
    dif.Gra      = |(c & GRA);
    dif.Grb      = |(c & GRB);
    dif.Grc      = |(c & GRC);
    dif.IncPC    = |(c & INC);
    dif.ADD      = |(c & ADDS);
    dif.MD_read  = |(c & MDRD);
    dif.Read     = |(c & RDS);
    dif.Write    = |(c & WRS);
`ifdef DATAPATH_SUB_EN
    dif.SUB      = |(c & SUBS);
`endif
    dif.Mdatain  = md;
  endtask

  task automatic cyc(logic [23:0] c, logic [31:0] md,
                     output logic [31:0] b);
    drive(c, md);
    #1;
    b = dif.bus_out;
    m_clk(c, md);
    @(posedge clock);
    #1;
  endtask

  vec_t        tbl [35];
  logic [31:0] b, eb;
  logic [23:0] c;
  logic [31:0] md;

  initial begin
    tbl[0]  = '{PCO|MARI|INC|ZLI,  32'h0,        32'h0,        3'd3, 32'h0};
    tbl[1]  = '{ZLO|PCI|MDRD|MDRI, 32'h10900000, 32'h1,        3'd1, 32'h1};
    tbl[2]  = '{MDRO|IRI,          32'h0,        32'h10900000, 3'd2, 32'h10900000};
    tbl[3]  = '{MDRD|MDRI,         32'h20,       32'h0,        3'd0, 32'h0};
    tbl[4]  = '{MDRO|GRB|RI,       32'h0,        32'h20,       3'd0, 32'h0};
    tbl[5]  = '{MDRD|MDRI,         32'hDEAD,     32'h0,        3'd0, 32'h0};
    tbl[6]  = '{MDRO|GRA|RI,       32'h0,        32'hDEAD,     3'd0, 32'h0};
    tbl[7]  = '{MDRD|MDRI,         32'h10900045, 32'h0,        3'd0, 32'h0};
    tbl[8]  = '{MDRO|IRI,          32'h0,        32'h10900045, 3'd2, 32'h10900045};
    tbl[9]  = '{GRB|BAO|YI,        32'h0,        32'h20,       3'd0, 32'h0};
    tbl[10] = '{CSO|ADDS|ZLI,      32'h0,        32'h45,       3'd0, 32'h0};
    tbl[11] = '{ZLO|MARI,          32'h0,        32'h65,       3'd3, 32'h65};
    tbl[12] = '{GRA|RO|MDRI,       32'h0,        32'hDEAD,     3'd0, 32'h0};
    tbl[13] = '{MDRO|WRS,          32'h0,        32'hDEAD,     3'd4, 32'hDEAD};
    tbl[14] = '{MDRD|MDRI,         32'h0007FFFF, 32'h0,        3'd0, 32'h0};
    tbl[15] = '{MDRO|IRI,          32'h0,        32'h0007FFFF, 3'd2, 32'h0007FFFF};
    tbl[16] = '{MDRD|MDRI,         32'h5,        32'h0,        3'd0, 32'h0};
    tbl[17] = '{MDRO|GRA|RI,       32'h0,        32'h5,        3'd0, 32'h0};
    tbl[18] = '{GRA|RO,            32'h0,        32'h5,        3'd0, 32'h0};
    tbl[19] = '{GRB|BAO|YI,        32'h0,        32'h0,        3'd0, 32'h0};
    tbl[20] = '{CSO|ADDS|ZLI|ZHI,  32'h0,        32'hFFFFFFFF, 3'd0, 32'h0};
    tbl[21] = '{ZLO,               32'h0,        32'hFFFFFFFF, 3'd0, 32'h0};
    tbl[22] = '{ZHO,               32'h0,        32'hFFFFFFFF, 3'd0, 32'h0};
    tbl[23] = '{MDRD|MDRI,         32'h8,        32'h0,        3'd0, 32'h0};
    tbl[24] = '{MDRO|INC|ZLI,      32'h0,        32'h8,        3'd0, 32'h0};
    tbl[25] = '{MDRD|MDRI,         32'h3,        32'h0,        3'd0, 32'h0};
    tbl[26] = '{MDRO|ZLO,          32'h0,        32'h3,        3'd0, 32'h0};
    tbl[27] = '{ZLO,               32'h0,        32'h9,        3'd0, 32'h0};
    tbl[28] = '{24'h0,             32'h0,        32'h0,        3'd0, 32'h0};
    tbl[29] = '{MDRD|MDRI,         32'hFFFFFFFF, 32'h0,        3'd0, 32'h0};
    tbl[30] = '{MDRO|INC|ZLI|ZHI,  32'h0,        32'hFFFFFFFF, 3'd0, 32'h0};
    tbl[31] = '{ZLO,               32'h0,        32'h0,        3'd0, 32'h0};
    tbl[32] = '{ZHO,               32'h0,        32'h0,        3'd0, 32'h0};
    tbl[33] = '{ZHO|MDRI,          32'h0,        32'h0,        3'd5, 32'h0};
    tbl[34] = '{PCO|PCI,           32'h0,        32'h1,        3'd1, 32'h1};

    drive(24'h0, 32'h0);
    m_reset();
    #12;
    chk("rst_pc", dif.pc_out, 32'h0);
    chk("rst_ir", dif.ir_out, 32'h0);
    chk("rst_mar", dif.mem_addr, 32'h0);
    chk("rst_mdr", dif.mem_wdata, 32'h0);
    chk("rst_bus", dif.bus_out, 32'h0);
    clear = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 35; i++) begin
      cyc(tbl[i].c, tbl[i].md, b);
      chk($sformatf("tbl%0d_bus", i), b, tbl[i].eb);
      unique case (tbl[i].pk)
        3'd1: chk($sformatf("tbl%0d_pc", i), dif.pc_out, tbl[i].pv);
        3'd2: chk($sformatf("tbl%0d_ir", i), dif.ir_out, tbl[i].pv);
        3'd3: chk($sformatf("tbl%0d_mar", i), dif.mem_addr, tbl[i].pv);
        3'd4: begin
          chk($sformatf("tbl%0d_wr", i), 32'(dif.mem_write), 32'h1);
          chk($sformatf("tbl%0d_wd", i), dif.mem_wdata, tbl[i].pv);
        end
        3'd5: chk($sformatf("tbl%0d_wd", i), dif.mem_wdata, tbl[i].pv);
        default: ;
      endcase
    end

    // mid-run reset with PC = 5 and R2 = 7
    cyc(MDRD|MDRI, 32'h5, b);
    cyc(MDRO|PCI, 32'h0, b);
    cyc(MDRD|MDRI, 32'h10900000, b);
    cyc(MDRO|IRI, 32'h0, b);
    cyc(MDRD|MDRI, 32'h7, b);
    cyc(MDRO|GRB|RI, 32'h0, b);
    chk("pre_rst_pc", dif.pc_out, 32'h5);
    drive(GRB|RO, 32'h0);
    #1;
    chk("pre_rst_r2", dif.bus_out, 32'h7);
    drive(MDRO|PCI|IRI|GRB|RI|MARI, 32'h0);
    #1;
    clear = 1'b0;
    #1;
    chk("async_pc", dif.pc_out, 32'h0);
    chk("async_ir", dif.ir_out, 32'h0);
    chk("async_mdr", dif.mem_wdata, 32'h0);
    chk("async_mar", dif.mem_addr, 32'h0);
    @(posedge clock);
    #1;
    chk("hold_pc", dif.pc_out, 32'h0);
    m_reset();
    #2;
    clear = 1'b1;
    drive(24'h0, 32'h0);
    @(posedge clock);
    #1;
    cyc(MDRD|MDRI, 32'h10900000, b);
    cyc(MDRO|IRI, 32'h0, b);
    cyc(GRB|RO, 32'h0, b);
    chk("rst_r2", b, 32'h0);
    cyc(GRA|RO, 32'h0, b);
    chk("rst_r1", b, 32'h0);
    cyc(ZLO, 32'h0, b);
    chk("rst_zlo", b, 32'h0);

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 24; k++) c[k] = ($urandom_range(3) == 0);
`ifndef DATAPATH_SUB_EN
      c = c & ~SUBS;
`endif
      md = $urandom;
      eb = m_bus(c);
      drive(c, md);
      #1;
      chk("rnd_rd", 32'(dif.mem_read), 32'(|(c & RDS)));
      chk("rnd_wr", 32'(dif.mem_write), 32'(|(c & WRS)));
      cyc(c, md, b);
      chk("rnd_bus", b, eb);
      chk("rnd_pc", dif.pc_out, m_pc);
      chk("rnd_ir", dif.ir_out, m_ir);
      chk("rnd_mar", dif.mem_addr, m_mar);
      chk("rnd_mdr", dif.mem_wdata, m_mdr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
